// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and types for the cache line memory controller
// Line geometry is fixed: 16 x 32-bit words per line, 13-bit line address.
package mem_pkg;

   localparam int WORDS_PER_LINE = 16;
   localparam int WORD_W         = 32;
   localparam int LINE_ADDR_W    = 13;
   localparam int WORD_ADDR_W    = 17;
   localparam int BEAT_W         = 4;
   localparam int IDX_W          = BEAT_W + 1;

   typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;
   typedef logic [LINE_ADDR_W-1:0]                line_addr_t;
   typedef logic [IDX_W-1:0]                      idx_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } mlc_state_t;

   function automatic logic [WORD_ADDR_W-1:0] wordAddr(input line_addr_t lineAddr,
                                                       input logic [BEAT_W-1:0] beat);
      return {lineAddr, beat};
   endfunction

endpackage

// File: rtl/mlc_beat_ctr.sv
// rtl/mlc_beat_ctr.sv - beat issue/return counter pair with an outstanding-read limit
// Counters are one bit wider than the beat index so "all 16 issued" is a distinct value.
module mlc_beat_ctr
   import mem_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic readMode,
   input  logic issueFire,
   input  logic rvalid,
   output idx_t issueIdx,
   output idx_t retIdx,
   output logic canIssue,
   output logic retFire
);

   localparam idx_t MAX_OUT  = idx_t'(MAX_OUTSTANDING);
   localparam idx_t ALL_BEAT = idx_t'(WORDS_PER_LINE);

   idx_t outstanding;

   assign outstanding = issueIdx - retIdx;

   // A return with nothing in flight is stale (e.g. from before a reset) and is dropped.
   assign retFire  = readMode && rvalid && (outstanding != '0);
   assign canIssue = (issueIdx < ALL_BEAT) && (!readMode || (outstanding < MAX_OUT));

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         issueIdx <= '0;
         retIdx   <= '0;
      end else begin
         if (issueFire) begin
            issueIdx <= issueIdx + idx_t'(1);
         end
         if (retFire) begin
            retIdx <= retIdx + idx_t'(1);
         end
      end
   end

endmodule

// File: rtl/mem_line_ctrl.sv
// rtl/mem_line_ctrl.sv - serialises cache line fills and write-backs onto a 32-bit word bus
// Optional MEM_LINE_CTRL_PERF_EN adds saturating fill_cnt/wb_cnt completion counters.
module mem_line_ctrl
   import mem_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_write,
   input  logic [LINE_ADDR_W-1:0]           req_line_addr,
   input  logic [WORDS_PER_LINE*WORD_W-1:0] req_wdata,
   output logic                             resp_valid,
   output logic [WORDS_PER_LINE*WORD_W-1:0] resp_rdata,
   output logic                             mem_valid,
   input  logic                             mem_ready,
   output logic                             mem_we,
   output logic [WORD_ADDR_W-1:0]           mem_addr,
   output logic [WORD_W-1:0]                mem_wdata,
   input  logic                             mem_rvalid,
   input  logic [WORD_W-1:0]                mem_rdata
`ifdef MEM_LINE_CTRL_PERF_EN
   ,
   output logic [31:0]                      fill_cnt,
   output logic [31:0]                      wb_cnt
`endif
);

   localparam idx_t LAST_BEAT = idx_t'(WORDS_PER_LINE - 1);

   mlc_state_t          state;
   line_addr_t          lineAddr;
   line_t               lineBuf;
   line_t               lineNext;
   line_t               respLine;
   idx_t                issueIdx;
   idx_t                retIdx;
   logic                canIssue;
   logic                retFire;
   logic                issueFire;
   logic                busy;
   logic [BEAT_W-1:0]   beat;
   logic [BEAT_W-1:0]   retSlot;

   assign busy       = (state == WB) || (state == FILL);
   assign beat       = issueIdx[BEAT_W-1:0];
   assign retSlot    = retIdx[BEAT_W-1:0];
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == DONE);
   assign resp_rdata = respLine;

   // Bus outputs derive from registered state only, so they hold steady while mem_ready is low.
   assign mem_valid = busy && canIssue;
   assign mem_we    = (state == WB);
   assign mem_addr  = mem_valid ? wordAddr(lineAddr, beat) : '0;
   assign mem_wdata = (mem_valid && (state == WB)) ? lineBuf[beat] : '0;
   assign issueFire = mem_valid && mem_ready;

   mlc_beat_ctr #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) u_beat_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (state == IDLE),
      .readMode (state == FILL),
      .issueFire(issueFire),
      .rvalid   (mem_rvalid),
      .issueIdx (issueIdx),
      .retIdx   (retIdx),
      .canIssue (canIssue),
      .retFire  (retFire)
   );

   always_comb begin
      lineNext = lineBuf;
      if (retFire) begin
         lineNext[retSlot] = mem_rdata;
      end
   end

   // The fill is assembled in lineBuf and copied out only on completion, so resp_rdata
   // keeps the previous line for the whole duration of the next fill.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         lineAddr <= '0;
         lineBuf  <= '0;
         respLine <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lineAddr <= req_line_addr;
                  lineBuf  <= req_wdata;
                  state    <= req_write ? WB : FILL;
               end
            end
            WB: begin
               if (issueFire && (issueIdx == LAST_BEAT)) begin
                  state <= DONE;
               end
            end
            FILL: begin
               lineBuf <= lineNext;
               if (retFire && (retIdx == LAST_BEAT)) begin
                  respLine <= lineNext;
                  state    <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_LINE_CTRL_PERF_EN
   logic doneWrite;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill_cnt  <= '0;
         wb_cnt    <= '0;
         doneWrite <= 1'b0;
      end else begin
         if (req_valid && req_ready) begin
            doneWrite <= req_write;
         end
         if (state == DONE) begin
            if (doneWrite && (wb_cnt != '1)) begin
               wb_cnt <= wb_cnt + 32'd1;
            end
            if (!doneWrite && (fill_cnt != '1)) begin
               fill_cnt <= fill_cnt + 32'd1;
            end
         end
      end
   end
`endif

endmodule
